// File: rtl/lsu_pkg.sv
// Shared definitions for the LSU request front-end: funct3 codes, FSM states
// and the request legality check.
package lsu_pkg;

    localparam int unsigned MEM_WORDS_DEFAULT = 7688;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WAIT,
        WR,
        RSP
    } state_t;

    // code[1:0] encodes the access size (00 byte, 01 half, 10 word) for every legal code
    function automatic logic access_error(
        input logic        wren,
        input logic [2:0]  code,
        input logic [31:0] addr,
        input int unsigned mem_words
    );
        logic illegal;
        logic misaligned;
        logic out_of_range;
        if (wren) begin
            illegal = !((code == SB) || (code == SH) || (code == SW));
        end else begin
            illegal = (code == 3'b011) || (code == 3'b110) || (code == 3'b111);
        end
        misaligned   = ((code[1:0] == 2'b01) && addr[0]) ||
                       ((code[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        out_of_range = ({2'b00, addr[31:2]} >= 32'(mem_words));
        return illegal || misaligned || out_of_range;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Lane steering for the LSU: extracts and extends load data from a memory word
// and merges sub-word store data into a read word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [31:0] st_data,
    input  logic [1:0]  addr,
    input  logic [2:0]  ld_type,
    output logic [31:0] ld_word,
    output logic [31:0] st_word
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[{addr, 3'b000} +: 8];
        half_lane = rdata[{addr[1], 4'b0000} +: 16];

        case (ld_type)
            LB:      ld_word = {{24{byte_lane[7]}}, byte_lane};
            LH:      ld_word = {{16{half_lane[15]}}, half_lane};
            LBU:     ld_word = {24'h000000, byte_lane};
            LHU:     ld_word = {16'h0000, half_lane};
            default: ld_word = rdata;
        endcase

        // Untouched lanes keep the value just read from memory
        st_word = rdata;
        case (ld_type)
            SB:      st_word[{addr, 3'b000} +: 8] = st_data[7:0];
            SH:      st_word[{addr[1], 4'b0000} +: 16] = st_data[15:0];
            default: st_word = st_data;
        endcase
    end

endmodule

// File: rtl/lsu_access_ctrl.sv
// Byte-addressed load/store front-end for a word-addressed data memory.
// Sub-word stores are done as read-modify-write; bad requests answer with err.
module lsu_access_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    input  logic        i_req_wren,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_st_data,
    input  logic [2:0]  i_ld_type,
    output logic        o_req_ready,
    output logic        o_rsp_valid,
    output logic        o_rsp_err,
    output logic [31:0] o_rsp_ld_data,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic        o_mem_wren,
    input  logic [31:0] i_mem_rdata
);

    state_t      state;
    logic        req_wren;
    logic [1:0]  req_lane;
    logic [31:0] req_st_data;
    logic [2:0]  req_type;
    logic        mem_wren_q;
    logic        handshake;
    logic        req_err;
    logic [31:0] ld_word;
    logic [31:0] st_word;

    assign handshake = i_req_valid && o_req_ready;
    assign req_err   = access_error(i_req_wren, i_ld_type, i_req_addr, MEM_WORDS);

    // A reset arriving while the strobe is up must not let the write land
    assign o_mem_wren = mem_wren_q && !i_rst;

    lsu_lane_align u_lane_align (
        .rdata   (i_mem_rdata),
        .st_data (req_st_data),
        .addr    (req_lane),
        .ld_type (req_type),
        .ld_word (ld_word),
        .st_word (st_word)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= IDLE;
            o_req_ready   <= 1'b1;
            o_rsp_valid   <= 1'b0;
            o_rsp_err     <= 1'b0;
            o_rsp_ld_data <= '0;
            o_mem_addr    <= '0;
            o_mem_wdata   <= '0;
            mem_wren_q    <= 1'b0;
            req_wren      <= 1'b0;
            req_lane      <= '0;
            req_st_data   <= '0;
            req_type      <= '0;
        end else begin
            o_rsp_valid <= 1'b0;
            o_rsp_err   <= 1'b0;
            mem_wren_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (handshake) begin
                        req_wren    <= i_req_wren;
                        req_lane    <= i_req_addr[1:0];
                        req_st_data <= i_req_st_data;
                        req_type    <= i_ld_type;
                        o_req_ready <= 1'b0;
                        if (req_err) begin
                            state         <= RSP;
                            o_rsp_valid   <= 1'b1;
                            o_rsp_err     <= 1'b1;
                            o_rsp_ld_data <= '0;
                        end else begin
                            o_mem_addr <= {2'b00, i_req_addr[31:2]};
                            if (i_req_wren && (i_ld_type == SW)) begin
                                state       <= WR;
                                mem_wren_q  <= 1'b1;
                                o_mem_wdata <= i_req_st_data;
                            end else begin
                                state <= RD;
                            end
                        end
                    end
                end
                RD: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (req_wren) begin
                        state       <= WR;
                        mem_wren_q  <= 1'b1;
                        o_mem_wdata <= st_word;
                    end else begin
                        state         <= RSP;
                        o_rsp_valid   <= 1'b1;
                        o_rsp_ld_data <= ld_word;
                    end
                end
                WR: begin
                    state         <= RSP;
                    o_rsp_valid   <= 1'b1;
                    o_rsp_ld_data <= '0;
                end
                RSP: begin
                    state       <= IDLE;
                    o_req_ready <= 1'b1;
                end
                default: begin
                    state       <= IDLE;
                    o_req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_access_ctrl.sv
// Self-checking bench for lsu_access_ctrl: directed scenarios followed by random
// requests, all judged against a byte-level reference model of the memory.
module tb_lsu_access_ctrl;

    localparam int unsigned MEM_WORDS = 7688;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_req_valid = 1'b0;
    logic        i_req_wren = 1'b0;
    logic [31:0] i_req_addr = '0;
    logic [31:0] i_req_st_data = '0;
    logic [2:0]  i_ld_type = '0;
    logic        o_req_ready;
    logic        o_rsp_valid;
    logic        o_rsp_err;
    logic [31:0] o_rsp_ld_data;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic        o_mem_wren;
    logic [31:0] i_mem_rdata = '0;

    bit [31:0] mem     [0:MEM_WORDS-1];
    bit [31:0] ref_mem [0:MEM_WORDS-1];
    int        wr_count = 0;
    int        checks = 0;
    int        errors = 0;

    lsu_access_ctrl #(.MEM_WORDS(MEM_WORDS)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_req_valid   (i_req_valid),
        .i_req_wren    (i_req_wren),
        .i_req_addr    (i_req_addr),
        .i_req_st_data (i_req_st_data),
        .i_ld_type     (i_ld_type),
        .o_req_ready   (o_req_ready),
        .o_rsp_valid   (o_rsp_valid),
        .o_rsp_err     (o_rsp_err),
        .o_rsp_ld_data (o_rsp_ld_data),
        .o_mem_addr    (o_mem_addr),
        .o_mem_wdata   (o_mem_wdata),
        .o_mem_wren    (o_mem_wren),
        .i_mem_rdata   (i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    // Synchronous word memory: read data appears the cycle after the address
    always @(posedge i_clk) begin
        if (o_mem_addr < MEM_WORDS) begin
            i_mem_rdata <= mem[o_mem_addr[12:0]];
            if (o_mem_wren) mem[o_mem_addr[12:0]] <= o_mem_wdata;
        end else begin
            i_mem_rdata <= '0;
        end
        if (o_mem_wren) wr_count <= wr_count + 1;
    end

    function automatic bit refErr(input bit wren, input logic [2:0] code, input logic [31:0] addr);
        bit     legal;
        longint size;
        if (wren) legal = code inside {3'd0, 3'd1, 3'd2};
        else      legal = code inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        size = longint'(1) << code[1:0];
        return !legal || ((longint'(addr) % size) != 0) || ((addr / 4) >= MEM_WORDS);
    endfunction

    function automatic logic [31:0] refLoad(input logic [31:0] word, input logic [31:0] addr,
                                            input logic [2:0] code);
        longint size, mask, v;
        size = longint'(1) << code[1:0];
        mask = (longint'(1) << (8 * size)) - 1;
        v    = (longint'(word) >> (8 * (addr % 4))) & mask;
        if (code < 4 && size < 4 && v >= (mask + 1) / 2) v = v - (mask + 1);
        return v[31:0];
    endfunction

    function automatic logic [31:0] refStore(input logic [31:0] word, input logic [31:0] addr,
                                             input logic [2:0] code, input logic [31:0] data);
        longint size, shift, mask, nv;
        size  = longint'(1) << code[1:0];
        shift = 8 * longint'(addr % 4);
        mask  = ((longint'(1) << (8 * size)) - 1) << shift;
        nv    = (longint'(word) & ~mask) | ((longint'(data) << shift) & mask);
        return nv[31:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Waits for ready, performs one handshake and waits (bounded) for the response pulse
    task automatic applyStimulus(input bit wren, input logic [31:0] addr, input logic [31:0] data,
                                 input logic [2:0] code, output logic [31:0] got_data,
                                 output logic got_err, output int lat, output int rdy_wait,
                                 output logic pulse_before);
        @(negedge i_clk);
        pulse_before = o_rsp_valid;
        rdy_wait = 0;
        while (!o_req_ready && rdy_wait < 20) begin
            @(negedge i_clk);
            rdy_wait++;
        end
        i_req_valid   = 1'b1;
        i_req_wren    = wren;
        i_req_addr    = addr;
        i_req_st_data = data;
        i_ld_type     = code;
        @(negedge i_clk);
        i_req_valid = 1'b0;
        lat = 1;
        while (!o_rsp_valid && lat < 20) begin
            @(negedge i_clk);
            lat++;
        end
        if (!o_rsp_valid) lat = 99;
        got_data = o_rsp_ld_data;
        got_err  = o_rsp_err;
    endtask

    task automatic runOp(input string tag, input bit wren, input logic [31:0] addr,
                         input logic [31:0] data, input logic [2:0] code);
        logic [31:0] got_data, exp_data, addr_before;
        logic        got_err, pulse;
        bit          exp_err;
        int          lat, rdy_wait, exp_lat, exp_writes, wc_before;
        int unsigned idx;
        idx         = addr / 4;
        exp_err     = refErr(wren, code, addr);
        addr_before = o_mem_addr;
        wc_before   = wr_count;
        exp_data    = '0;
        exp_writes  = 0;
        if (exp_err) begin
            exp_lat = 1;
        end else if (wren) begin
            exp_lat = (code == 3'b010) ? 2 : 4;
            exp_writes = 1;
            ref_mem[idx] = refStore(ref_mem[idx], addr, code, data);
        end else begin
            exp_lat  = 3;
            exp_data = refLoad(ref_mem[idx], addr, code);
        end
        applyStimulus(wren, addr, data, code, got_data, got_err, lat, rdy_wait, pulse);
        checkOutput({tag, ".ready_wait"}, 32'(rdy_wait), 32'd0);
        checkOutput({tag, ".pulse_low"}, {31'd0, pulse}, 32'd0);
        checkOutput({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        checkOutput({tag, ".err"}, {31'd0, got_err}, {31'd0, exp_err});
        checkOutput({tag, ".data"}, got_data, exp_data);
        checkOutput({tag, ".writes"}, 32'(wr_count - wc_before), 32'(exp_writes));
        checkOutput({tag, ".mem_addr"}, o_mem_addr, exp_err ? addr_before : 32'(idx));
        if (idx < MEM_WORDS) checkOutput({tag, ".mem_word"}, mem[idx], ref_mem[idx]);
    endtask

    initial begin
        int          wc0;
        logic [31:0] raddr;
        int unsigned word;

        $display("[TB] starting lsu_access_ctrl bench");
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        checkOutput("reset.ready", {31'd0, o_req_ready}, 32'd1);
        checkOutput("reset.rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
        checkOutput("reset.rsp_err", {31'd0, o_rsp_err}, 32'd0);
        checkOutput("reset.ld_data", o_rsp_ld_data, 32'd0);
        checkOutput("reset.mem_addr", o_mem_addr, 32'd0);
        checkOutput("reset.mem_wdata", o_mem_wdata, 32'd0);
        checkOutput("reset.mem_wren", {31'd0, o_mem_wren}, 32'd0);

        runOp("sw_basic", 1'b1, 32'h100, 32'hDEADBEEF, 3'b010);
        checkOutput("sw_basic.word", mem[32'h40], 32'hDEADBEEF);

        runOp("sw_pre_sb", 1'b1, 32'h100, 32'h11223344, 3'b010);
        runOp("sb_lane2", 1'b1, 32'h102, 32'h000000AA, 3'b000);
        checkOutput("sb_lane2.word", mem[32'h40], 32'h11AA3344);

        runOp("sw_pre_ld", 1'b1, 32'h100, 32'h8899AABB, 3'b010);
        runOp("lb_0", 1'b0, 32'h100, 32'h0, 3'b000);
        checkOutput("lb_0.const", o_rsp_ld_data, 32'hFFFFFFBB);
        runOp("lbu_3", 1'b0, 32'h103, 32'h0, 3'b100);
        checkOutput("lbu_3.const", o_rsp_ld_data, 32'h00000088);
        runOp("lh_2", 1'b0, 32'h102, 32'h0, 3'b001);
        checkOutput("lh_2.const", o_rsp_ld_data, 32'hFFFF8899);
        runOp("lhu_0", 1'b0, 32'h100, 32'h0, 3'b101);
        runOp("lhu_2", 1'b0, 32'h102, 32'h0, 3'b101);
        runOp("lw_0", 1'b0, 32'h100, 32'h0, 3'b010);
        checkOutput("lw_0.const", o_rsp_ld_data, 32'h8899AABB);

        runOp("err_lw_mis", 1'b0, 32'h101, 32'h0, 3'b010);
        runOp("err_sh_mis", 1'b1, 32'h103, 32'h5555, 3'b001);
        runOp("err_ld_011", 1'b0, 32'h100, 32'h0, 3'b011);
        runOp("err_st_100", 1'b1, 32'h100, 32'h77, 3'b100);
        runOp("err_lw_oor", 1'b0, 32'h7820, 32'h0, 3'b010);
        runOp("err_sw_oor", 1'b1, 32'h7820, 32'h12345678, 3'b010);
        runOp("lw_last", 1'b0, 32'h781C, 32'h0, 3'b010);

        // Reset lands while the SH read-modify-write sits in WAIT
        runOp("sw_pre_rst", 1'b1, 32'h200, 32'hCAFEF00D, 3'b010);
        wc0 = wr_count;
        @(negedge i_clk);
        i_req_valid = 1'b1; i_req_wren = 1'b1; i_req_addr = 32'h200;
        i_req_st_data = 32'h00001234; i_ld_type = 3'b001;
        @(negedge i_clk);
        i_req_valid = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b1;
        i_req_valid = 1'b1; i_req_wren = 1'b1; i_req_addr = 32'h200;
        i_req_st_data = 32'h0BAD0BAD; i_ld_type = 3'b010;
        @(negedge i_clk);
        i_rst = 1'b0;
        i_req_valid = 1'b0;
        checkOutput("rst_mid.ready", {31'd0, o_req_ready}, 32'd1);
        checkOutput("rst_mid.wren", {31'd0, o_mem_wren}, 32'd0);
        checkOutput("rst_mid.rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
        repeat (5) @(negedge i_clk);
        checkOutput("rst_mid.writes", 32'(wr_count - wc0), 32'd0);
        checkOutput("rst_mid.word", mem[32'h80], 32'hCAFEF00D);
        checkOutput("rst_mid.rsp_after", {31'd0, o_rsp_valid}, 32'd0);

        runOp("b2b_a", 1'b0, 32'h200, 32'h0, 3'b010);
        runOp("b2b_b", 1'b1, 32'h201, 32'h000000EE, 3'b000);
        runOp("b2b_c", 1'b0, 32'h200, 32'h0, 3'b010);

        for (int n = 0; n < 80; n++) begin
            word  = ($urandom_range(0, 7) == 0) ? (MEM_WORDS - 1 + $urandom_range(0, 1))
                                                : $urandom_range(0, 15);
            raddr = (word * 4) + $urandom_range(0, 3);
            runOp($sformatf("rand%0d", n), 1'($urandom_range(0, 1)), raddr, $urandom,
                  3'($urandom_range(0, 7)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
